// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline definitions: controller state encoding, latency width and
// default writeback latencies used by the hazard controller and pipeline top.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HAZ   = 2'd1,
    MISS  = 2'd2,
    FLUSH = 2'd3
  } pipe_state_t;

  localparam int LAT_W        = 4;
  localparam int DEF_ALU_LAT  = 1;
  localparam int DEF_LONG_LAT = 4;

  function automatic logic [LAT_W-1:0] issue_latency(input logic long_op,
                                                     input int   alu_lat,
                                                     input int   long_lat);
    return long_op ? LAT_W'(long_lat) : LAT_W'(alu_lat);
  endfunction

endpackage

// File: rtl/pipe_ctrl_sb_entry.sv
// One scoreboard slot: a pending flag plus a writeback countdown that
// retires the register when it steps from 1 to 0.
module sb_entry
  import pipe_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             issue,
  input  logic             hold,
  input  logic [LAT_W-1:0] lat,
  output logic             pend,
  output logic             retire
);

  logic [LAT_W-1:0] count;

  assign retire = pend && (count == LAT_W'(1)) && !hold;

  // A same-cycle reissue wins over the retire so the register stays pending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      pend  <= 1'b0;
    end else if (issue) begin
      count <= lat;
      pend  <= 1'b1;
    end else if (!hold && (count != '0)) begin
      count <= count - LAT_W'(1);
      pend  <= (count != LAT_W'(1));
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: stall/flush/freeze sequencing, per-register
// writeback scoreboard and saturating performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NREGS    = 32,
  parameter int RIDX_W   = 5,
  parameter int ALU_LAT  = DEF_ALU_LAT,
  parameter int LONG_LAT = DEF_LONG_LAT,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [RIDX_W-1:0] rs,
  input  logic [RIDX_W-1:0] rt,
  input  logic [RIDX_W-1:0] rd,
  input  logic              use_rs,
  input  logic              use_rt,
  input  logic              reg_write,
  input  logic              long_write,
  input  logic              branch_ex,
  input  logic              imiss,
  input  logic              dmiss,
  output logic              pc_we,
  output logic              IFID_we,
  output logic              IFID_reset,
  output logic              IDEX_we,
  output logic              IDEX_reset,
  output logic              IRB_we,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
);

  pipe_state_t      cur_state, next_state;
  logic [NREGS-1:1] pend, retire;
  logic [NREGS-1:0] busy;
  logic             freeze, hazard, issue;
  logic [LAT_W-1:0] lat;

  // A register retiring this cycle is forwarded, so it no longer blocks ID.
  assign freeze = imiss | dmiss;
  assign busy   = {pend & ~retire, 1'b0};
  assign hazard = id_valid && ((use_rs && busy[rs]) ||
                               (use_rt && busy[rt]) ||
                               (reg_write && busy[rd]));
  assign lat    = issue_latency(long_write, ALU_LAT, LONG_LAT);
  assign issue  = id_valid && reg_write && (rd != '0) && (next_state == RUN);

  for (genvar i = 1; i < NREGS; i++) begin : g_sb
    sb_entry u_sb (
      .clk    (clk),
      .reset  (reset),
      .issue  (issue && (rd == RIDX_W'(i))),
      .hold   (freeze),
      .lat    (lat),
      .pend   (pend[i]),
      .retire (retire[i])
    );
  end

  assign IRB_we = |retire;
  assign state  = cur_state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state <= RUN;
    end else begin
      cur_state <= next_state;
    end
  end

  always_comb begin
    next_state = RUN;
    pc_we      = 1'b1;
    IFID_we    = 1'b1;
    IDEX_we    = 1'b1;
    IFID_reset = 1'b0;
    IDEX_reset = 1'b0;
    if (freeze) begin
      next_state = MISS;
    end else if (branch_ex) begin
      next_state = FLUSH;
    end else if (hazard) begin
      next_state = HAZ;
    end
    case (next_state)
      HAZ: begin
        pc_we      = 1'b0;
        IFID_we    = 1'b0;
        IDEX_reset = 1'b1;
      end
      MISS: begin
        pc_we   = 1'b0;
        IFID_we = 1'b0;
        IDEX_we = 1'b0;
      end
      FLUSH: begin
        IFID_reset = 1'b1;
        IDEX_reset = 1'b1;
      end
      default: ;
    endcase
    // Reset drives the pipeline registers into flush without waiting for clk.
    if (!reset) begin
      pc_we      = 1'b0;
      IFID_we    = 1'b0;
      IDEX_we    = 1'b0;
      IFID_reset = 1'b1;
      IDEX_reset = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (((next_state == HAZ) || (next_state == MISS)) && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if ((next_state == FLUSH) && (cur_state != FLUSH) && (flush_count != '1)) begin
        flush_count <= flush_count + CNT_W'(1);
      end
    end
  end

  // Simultaneous retirements share one write port; software must avoid them.
  wb_single_port: assert property (@(posedge clk) disable iff (!reset) $onehot0(retire))
    else $warning("two register writebacks retired in the same cycle");

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: writeback timing is tracked by a queue of
// expected retire cycles, pipeline controls are checked cycle by cycle.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int NREGS    = 32;
  localparam int RIDX_W   = 5;
  localparam int ALU_LAT  = 1;
  localparam int LONG_LAT = 4;
  localparam int CNT_W    = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              id_valid, use_rs, use_rt, reg_write, long_write;
  logic              branch_ex, imiss, dmiss;
  logic [RIDX_W-1:0] rs, rt, rd;
  logic              pc_we, IFID_we, IFID_reset, IDEX_we, IDEX_reset, IRB_we;
  logic [1:0]        state;
  logic [CNT_W-1:0]  stall_cycles, flush_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int exp_q[$];

  pipe_ctrl #(
    .NREGS(NREGS), .RIDX_W(RIDX_W), .ALU_LAT(ALU_LAT),
    .LONG_LAT(LONG_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .rs(rs), .rt(rt), .rd(rd),
    .use_rs(use_rs), .use_rt(use_rt), .reg_write(reg_write),
    .long_write(long_write), .branch_ex(branch_ex),
    .imiss(imiss), .dmiss(dmiss),
    .pc_we(pc_we), .IFID_we(IFID_we), .IFID_reset(IFID_reset),
    .IDEX_we(IDEX_we), .IDEX_reset(IDEX_reset), .IRB_we(IRB_we),
    .state(state), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives one ID-stage cycle, then settles and matches IRB_we to the queue.
  task automatic apply_stimulus(input logic v, input logic [RIDX_W-1:0] s,
                                input logic [RIDX_W-1:0] t, input logic [RIDX_W-1:0] d,
                                input logic urs, input logic urt, input logic wr,
                                input logic lng, input logic br, input logic im,
                                input logic dm);
    id_valid   = v;
    rs         = s;
    rt         = t;
    rd         = d;
    use_rs     = urs;
    use_rt     = urt;
    reg_write  = wr;
    long_write = lng;
    branch_ex  = br;
    imiss      = im;
    dmiss      = dm;
    #1;
    if ((exp_q.size() != 0) && (exp_q[0] == cyc)) begin
      void'(exp_q.pop_front());
      check_output("irb_we_due", 32'(IRB_we), 32'd1);
    end else if (IRB_we) begin
      check_output("irb_we_spurious", 32'(IRB_we), 32'd0);
    end
  endtask

  task automatic idle();
    apply_stimulus('0, 5'd0, 5'd0, 5'd0, '0, '0, '0, '0, '0, '0, '0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int c;

    idle();
    #1;
    check_output("rst_state", 32'(state), 32'(RUN));
    check_output("rst_pc_we", 32'(pc_we), 32'd0);
    check_output("rst_ifid_we", 32'(IFID_we), 32'd0);
    check_output("rst_idex_we", 32'(IDEX_we), 32'd0);
    check_output("rst_ifid_reset", 32'(IFID_reset), 32'd1);
    check_output("rst_idex_reset", 32'(IDEX_reset), 32'd1);
    check_output("rst_irb_we", 32'(IRB_we), 32'd0);
    check_output("rst_stall", 32'(stall_cycles), 32'd0);
    check_output("rst_flush", 32'(flush_count), 32'd0);

    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc   = 0;
    idle();
    check_output("release_state", 32'(state), 32'(RUN));
    check_output("release_pc_we", 32'(pc_we), 32'd1);
    next_cycle();

    // RAW on a long write: three bubbles, then the reader goes.
    c = cyc;
    exp_q.push_back(c + LONG_LAT);
    apply_stimulus('1, 5'd0, 5'd0, 5'd5, '0, '0, '1, '1, '0, '0, '0);
    check_output("raw_issue_pc_we", 32'(pc_we), 32'd1);
    next_cycle();
    for (int k = 1; k <= 3; k++) begin
      apply_stimulus('1, 5'd5, 5'd0, 5'd0, '1, '0, '0, '0, '0, '0, '0);
      check_output("raw_haz_pc_we", 32'(pc_we), 32'd0);
      check_output("raw_haz_bubble", 32'(IDEX_reset), 32'd1);
      if (k >= 2) check_output("raw_haz_state", 32'(state), 32'(HAZ));
      next_cycle();
    end
    apply_stimulus('1, 5'd5, 5'd0, 5'd0, '1, '0, '0, '0, '0, '0, '0);
    check_output("raw_release_pc_we", 32'(pc_we), 32'd1);
    check_output("raw_release_bubble", 32'(IDEX_reset), 32'd0);
    check_output("raw_stall", 32'(stall_cycles), 32'd3);
    next_cycle();
    idle();
    check_output("raw_state_run", 32'(state), 32'(RUN));
    check_output("raw_drain", 32'(exp_q.size()), 32'd0);
    next_cycle();

    // Branch resolves while a dependent write to r9 is stalled in ID.
    c = cyc;
    exp_q.push_back(c + LONG_LAT);
    apply_stimulus('1, 5'd0, 5'd0, 5'd5, '0, '0, '1, '1, '0, '0, '0);
    next_cycle();
    apply_stimulus('1, 5'd5, 5'd0, 5'd9, '1, '0, '1, '0, '0, '0, '0);
    check_output("br_haz_pc_we", 32'(pc_we), 32'd0);
    next_cycle();
    apply_stimulus('1, 5'd5, 5'd0, 5'd9, '1, '0, '1, '0, '1, '0, '0);
    check_output("br_ifid_reset", 32'(IFID_reset), 32'd1);
    check_output("br_idex_reset", 32'(IDEX_reset), 32'd1);
    check_output("br_pc_we", 32'(pc_we), 32'd1);
    next_cycle();
    idle();
    check_output("br_state", 32'(state), 32'(FLUSH));
    check_output("br_flush_count", 32'(flush_count), 32'd1);
    next_cycle();
    apply_stimulus('1, 5'd9, 5'd0, 5'd0, '1, '0, '0, '0, '0, '0, '0);
    check_output("br_r9_free", 32'(pc_we), 32'd1);
    check_output("br_stall", 32'(stall_cycles), 32'd4);
    next_cycle();
    idle();
    check_output("br_drain", 32'(exp_q.size()), 32'd0);
    next_cycle();

    // Data miss for five cycles while r7 has two cycles left.
    c = cyc;
    exp_q.push_back(c + LONG_LAT + 5);
    apply_stimulus('1, 5'd0, 5'd0, 5'd7, '0, '0, '1, '1, '0, '0, '0);
    next_cycle();
    idle();
    next_cycle();
    idle();
    next_cycle();
    for (int k = 0; k < 5; k++) begin
      apply_stimulus('1, 5'd0, 5'd0, 5'd8, '0, '0, '1, '0, '0, '0, '1);
      check_output("miss_pc_we", 32'(pc_we), 32'd0);
      check_output("miss_ifid_we", 32'(IFID_we), 32'd0);
      check_output("miss_idex_we", 32'(IDEX_we), 32'd0);
      check_output("miss_ifid_reset", 32'(IFID_reset), 32'd0);
      check_output("miss_idex_reset", 32'(IDEX_reset), 32'd0);
      next_cycle();
    end
    idle();
    check_output("miss_stall", 32'(stall_cycles), 32'd9);
    check_output("miss_state", 32'(state), 32'(MISS));
    next_cycle();
    idle();
    next_cycle();
    idle();
    check_output("miss_drain", 32'(exp_q.size()), 32'd0);
    next_cycle();

    // Register 0 is never tracked.
    apply_stimulus('1, 5'd0, 5'd0, 5'd0, '1, '0, '1, '1, '0, '0, '0);
    check_output("r0_pc_we", 32'(pc_we), 32'd1);
    next_cycle();
    apply_stimulus('1, 5'd0, 5'd0, 5'd0, '1, '1, '1, '0, '0, '0, '0);
    check_output("r0_no_haz", 32'(pc_we), 32'd1);
    check_output("r0_no_bubble", 32'(IDEX_reset), 32'd0);
    next_cycle();
    for (int k = 0; k < 6; k++) begin
      idle();
      next_cycle();
    end

    // Retire and reissue of r4 in the same cycle keeps r4 pending.
    c = cyc;
    exp_q.push_back(c + ALU_LAT);
    apply_stimulus('1, 5'd0, 5'd0, 5'd4, '0, '0, '1, '0, '0, '0, '0);
    next_cycle();
    exp_q.push_back(c + 1 + LONG_LAT);
    apply_stimulus('1, 5'd0, 5'd0, 5'd4, '0, '0, '1, '1, '0, '0, '0);
    check_output("waw_reissue_pc_we", 32'(pc_we), 32'd1);
    next_cycle();
    apply_stimulus('1, 5'd4, 5'd0, 5'd0, '1, '0, '0, '0, '0, '0, '0);
    check_output("waw_pend_kept", 32'(pc_we), 32'd0);
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      idle();
      next_cycle();
    end
    idle();
    check_output("waw_drain", 32'(exp_q.size()), 32'd0);
    next_cycle();

    // Reset lands mid-miss with r1..r3 pending.
    apply_stimulus('1, 5'd0, 5'd0, 5'd1, '0, '0, '1, '1, '0, '0, '0);
    next_cycle();
    apply_stimulus('1, 5'd0, 5'd0, 5'd2, '0, '0, '1, '1, '0, '0, '0);
    next_cycle();
    apply_stimulus('1, 5'd0, 5'd0, 5'd3, '0, '0, '1, '1, '0, '0, '0);
    next_cycle();
    apply_stimulus('0, 5'd0, 5'd0, 5'd0, '0, '0, '0, '0, '0, '0, '1);
    next_cycle();
    apply_stimulus('0, 5'd0, 5'd0, 5'd0, '0, '0, '0, '0, '0, '0, '1);
    reset = 1'b0;
    #1;
    check_output("rstm_state", 32'(state), 32'(RUN));
    check_output("rstm_irb_we", 32'(IRB_we), 32'd0);
    check_output("rstm_ifid_reset", 32'(IFID_reset), 32'd1);
    check_output("rstm_idex_reset", 32'(IDEX_reset), 32'd1);
    check_output("rstm_pc_we", 32'(pc_we), 32'd0);
    check_output("rstm_idex_we", 32'(IDEX_we), 32'd0);
    check_output("rstm_stall", 32'(stall_cycles), 32'd0);
    next_cycle();
    idle();
    next_cycle();
    reset = 1'b1;
    idle();
    check_output("rstm_run", 32'(state), 32'(RUN));
    next_cycle();
    apply_stimulus('1, 5'd1, 5'd2, 5'd0, '1, '1, '0, '0, '0, '0, '0);
    check_output("rstm_no_pend", 32'(pc_we), 32'd1);
    next_cycle();
    for (int k = 0; k < 6; k++) begin
      idle();
      next_cycle();
    end

    // Stall counter saturation.
    for (int k = 0; k < 65534; k++) begin
      apply_stimulus('0, 5'd0, 5'd0, 5'd0, '0, '0, '0, '0, '0, '0, '1);
      next_cycle();
    end
    apply_stimulus('0, 5'd0, 5'd0, 5'd0, '0, '0, '0, '0, '0, '0, '1);
    check_output("sat_pre", 32'(stall_cycles), 32'h0000_FFFE);
    next_cycle();
    apply_stimulus('0, 5'd0, 5'd0, 5'd0, '0, '0, '0, '0, '0, '0, '1);
    next_cycle();
    apply_stimulus('0, 5'd0, 5'd0, 5'd0, '0, '0, '0, '0, '0, '0, '1);
    check_output("sat_hit", 32'(stall_cycles), 32'h0000_FFFF);
    next_cycle();
    idle();
    check_output("sat_hold", 32'(stall_cycles), 32'h0000_FFFF);
    check_output("final_drain", 32'(exp_q.size()), 32'd0);
    next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
